// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed address/data bus engine.
package rtc_bus_pkg;

   // Transaction phases; timed phases share one down-counter in the engine.
   typedef enum logic [3:0] {
      StIdle,
      StASetup,
      StAStrobe,
      StAHold,
      StGap,
      StDSetup,
      StDStrobe,
      StDHold,
      StDone
   } state_t;

   // Pin levels while the bus is parked.
   localparam logic AD_IDLE = 1'b1;
   localparam logic CS_IDLE = 1'b1;
   localparam logic RD_IDLE = 1'b1;
   localparam logic WR_IDLE = 1'b1;

   // Encoding of the rw request bit.
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   // Default timing, in clock cycles.
   localparam int unsigned T_SU_DEFAULT  = 2;
   localparam int unsigned T_PW_DEFAULT  = 5;
   localparam int unsigned T_HD_DEFAULT  = 2;
   localparam int unsigned T_GAP_DEFAULT = 3;

endpackage

// File: rtl/rtc_bus_cycle.sv
// Single-transaction engine for the RTC multiplexed AD bus: address phase, turnaround,
// data phase, each with programmable setup / strobe / hold timing. All outputs registered.
module rtc_bus_cycle
   import rtc_bus_pkg::*;
#(
   parameter int unsigned T_SU  = T_SU_DEFAULT,
   parameter int unsigned T_PW  = T_PW_DEFAULT,
   parameter int unsigned T_HD  = T_HD_DEFAULT,
   parameter int unsigned T_GAP = T_GAP_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rw,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   input  logic [7:0] d_in,
   output logic [7:0] d_out,
   output logic       d_oe,
   output logic       AD,
   output logic       CS,
   output logic       RD,
   output logic       WR
);

   // Counter reload values: a state lasting N cycles is entered with N-1 and left at 0.
   localparam logic [7:0] SU_LOAD  = 8'(T_SU - 1);
   localparam logic [7:0] PW_LOAD  = 8'(T_PW - 1);
   localparam logic [7:0] HD_LOAD  = 8'(T_HD - 1);
   localparam logic [7:0] GAP_LOAD = 8'(T_GAP - 1);

   state_t     state;
   logic [7:0] cnt;
   logic       rw_q;
   logic [7:0] wdata_q;

   logic       last;
   assign last = (cnt == 8'd0);

   // Phase sequencer; every pin is updated on the edge that enters the phase it belongs to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= StIdle;
         cnt     <= 8'd0;
         rw_q    <= RW_WRITE;
         wdata_q <= 8'h00;
         busy    <= 1'b0;
         done    <= 1'b0;
         rdata   <= 8'h00;
         d_out   <= 8'h00;
         d_oe    <= 1'b0;
         AD      <= AD_IDLE;
         CS      <= CS_IDLE;
         RD      <= RD_IDLE;
         WR      <= WR_IDLE;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  rw_q    <= rw;
                  wdata_q <= wdata;
                  state   <= StASetup;
                  cnt     <= SU_LOAD;
                  busy    <= 1'b1;
                  AD      <= 1'b0;
                  d_oe    <= 1'b1;
                  d_out   <= addr;
                  CS      <= CS_IDLE;
                  RD      <= RD_IDLE;
                  WR      <= WR_IDLE;
               end
            end
            StASetup: begin
               if (last) begin
                  // The address is latched by the RTC with a WR strobe.
                  state <= StAStrobe;
                  cnt   <= PW_LOAD;
                  CS    <= 1'b0;
                  WR    <= 1'b0;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            StAStrobe: begin
               if (last) begin
                  state <= StAHold;
                  cnt   <= HD_LOAD;
                  CS    <= CS_IDLE;
                  WR    <= WR_IDLE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            StAHold: begin
               if (last) begin
                  state <= StGap;
                  cnt   <= GAP_LOAD;
                  AD    <= 1'b1;
                  if (rw_q == RW_READ) begin
                     d_oe <= 1'b0;
                  end else begin
                     d_oe  <= 1'b1;
                     d_out <= wdata_q;
                  end
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            StGap: begin
               if (last) begin
                  state <= StDSetup;
                  cnt   <= SU_LOAD;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            StDSetup: begin
               if (last) begin
                  state <= StDStrobe;
                  cnt   <= PW_LOAD;
                  CS    <= 1'b0;
                  if (rw_q == RW_READ) begin
                     RD <= 1'b0;
                  end else begin
                     WR <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            StDStrobe: begin
               if (last) begin
                  // Capture on the same edge RD rises, while the RTC still drives D.
                  if (rw_q == RW_READ) begin
                     rdata <= d_in;
                  end
                  state <= StDHold;
                  cnt   <= HD_LOAD;
                  CS    <= CS_IDLE;
                  RD    <= RD_IDLE;
                  WR    <= WR_IDLE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            StDHold: begin
               if (last) begin
                  state <= StDone;
                  cnt   <= 8'd0;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  d_oe  <= 1'b0;
                  AD    <= AD_IDLE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            StDone: begin
               // start is ignored here; the next request is accepted from StIdle.
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/rtc_bus_cycle.md
Name: rtc_bus_cycle

Overview:
- Single-transaction engine for the RTC's multiplexed address/data bus. It takes one read or write request at a time from the init, read or write control FSMs.
- For each request it generates the AD/CS/RD/WR pin sequence with programmable timing, drives the outbound byte, and captures the returned byte.
- Sits directly downstream of the control FSMs and upstream of the tristate D-bus buffer. It replaces hand-sequenced strobes in each FSM.

Parameters:
T_SU, 2, setup cycles before each strobe (1..255)
T_PW, 5, strobe low-width cycles (1..255)
T_HD, 2, hold cycles after each strobe rises (1..255)
T_GAP, 3, turnaround cycles between address and data phase (1..255)

Ports:
clk  in  1  system clock (single clock domain)
reset  in  1  synchronous, active-high reset
start  in  1  request strobe, sampled only in IDLE
rw  in  1  1 = read, 0 = write; latched with start
addr  in  8  RTC register address; latched with start
wdata  in  8  write byte; latched with start
busy  out  1  high while a transaction is in progress
done  out  1  one-cycle pulse at end of transaction
rdata  out  8  byte captured on read; holds until the next read
d_in  in  8  D bus as seen from the pin buffer
d_out  out  8  byte to drive onto D
d_oe  out  1  1 = buffer drives D
AD  out  1  0 = address phase, 1 = data phase
CS  out  1  chip select, active-low
RD  out  1  read strobe, active-low
WR  out  1  write strobe, active-low

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered, so strobes are glitch-free.
- Reset values: state IDLE, AD=1, CS=1, RD=1, WR=1, d_oe=0, d_out=0x00, rdata=0x00, busy=0, done=0.
- States: IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE.
- Timing: each timed state lasts exactly its parameter count of cycles, tracked by an 8-bit down-counter reloaded on each state entry.
- IDLE: if start=1, latch rw/addr/wdata and go to A_SETUP; busy=1 from the next cycle.
- A_SETUP: AD=0, d_oe=1, d_out=addr, CS=1, WR=1.
- A_STROBE: CS=0, WR=0, address still driven.
- A_HOLD: CS=1, WR=1, address still driven.
- GAP: AD=1, CS/RD/WR high.
  - Write: d_oe=1, d_out=wdata.
  - Read: d_oe=0, and it stays 0 for the rest of the transaction.
- D_SETUP: unchanged from GAP.
- D_STROBE: CS=0, plus RD=0 for a read or WR=0 for a write.
  - Read capture: rdata <= d_in on the last D_STROBE cycle, before RD rises.
- D_HOLD: CS/RD/WR high; a write keeps driving wdata.
- DONE (1 cycle): done=1, busy=0, d_oe=0, AD=1, then IDLE.
- Latency: start sampled at cycle 0 gives done at cycle 1 + 2*(T_SU+T_PW+T_HD) + T_GAP (22 with defaults).
- Next start: the earliest accepted start is the cycle after DONE.
- start while busy or in DONE: ignored, with no queueing.
- Input changes after the start cycle do not affect the transaction in progress.
- rdata is unchanged by writes.
- Reset mid-transaction: on the next edge all outputs take their reset values, with no done pulse and any partial read discarded.
- Never permitted: CS low simultaneously with both RD and WR low; d_oe=1 while RD=0.

Decomposition:
- Shared package rtc_bus_pkg:
  - state enum;
  - idle pin constants (AD/CS/RD/WR = 1);
  - RW_READ/RW_WRITE constants;
  - default timing constants.
- No sub-module: the phase counter is inline.

Test Plan:
1. Write: start, rw=0, addr=0x21, wdata=0x59, defaults.
   - AD=0 with d_out=0x21 and a WR low pulse of 5 cycles.
   - Then AD=1 with d_out=0x59 and a WR low pulse of 5 cycles.
   - done at cycle 22; RD stays 1 throughout.
2. Read: rw=1, addr=0x22, d_in=0x37 during the data phase.
   - d_oe=0 from GAP onward, RD low for 5 cycles.
   - rdata=0x37 when done=1; WR is low only in the address phase.
3. Start pulses every cycle while busy.
   - Exactly one transaction per done.
   - The latched addr is never altered by later inputs.
4. Reset asserted during D_STROBE of a read.
   - The next cycle shows AD=CS=RD=WR=1, d_oe=0, busy=0, rdata=0x00.
   - No done pulse.
5. Start the cycle after done: a second transaction begins, with busy=1 on the following cycle.
6. Override all timing parameters to 1.
   - done 8 cycles after start.
   - Each strobe is low for exactly 1 cycle.
